// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_pkg
//  Description : Shared definitions for the MULT/DIV sequencer: FSM state
//                encoding, operation codes and the iteration-counter width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

   // Sequencer states. The width is fixed so the encoding is stable
   // across tools.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } md_state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int unsigned MD_WIDTH_DEFAULT = 32;

   // Counter width. A counter running 0 .. WIDTH-1 needs $clog2(WIDTH)
   // bits; the guard keeps it at least one bit wide.
   function automatic int unsigned md_cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : mult_div_pkg
`default_nettype wire

// File: rtl/md_cond_neg.sv
`default_nettype none
// ============================================================================
//  Module      : md_cond_neg
//  Description : Combinational conditional two's-complement negate.
//                res_o = neg_i ? -val_i : val_i, modulo 2^WIDTH.
//  Ports       : val_i [WIDTH] - input value
//                neg_i         - 1 = negate
//                res_o [WIDTH] - result
//  Revision    : 1.0 - initial release
// ============================================================================
module md_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] res_o
);

   assign res_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule : md_cond_neg
`default_nettype wire

// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_seq
//  Description : Multicycle signed MULT/DIV sequencer. Radix-2 Booth multiply
//                or restoring divide on magnitudes, WIDTH iterations, then a
//                sign-fix cycle and a one-cycle done pulse.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                start, op    - request (op 0 = MULT, 1 = DIV), IDLE only
//                a, b         - operands, latched on an accepted start
//                hi, lo       - MULT: product high/low; DIV: remainder/quotient
//                busy         - high in every state except IDLE
//                done         - one-cycle completion pulse
//                div0         - divide by zero, valid with done
//  Config      : MULT_DIV_EARLY_OUT_EN - when defined, a MULT with a zero
//                operand completes in one cycle with hi = lo = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int unsigned       CNT_W    = md_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q;      // Booth accumulator / divide remainder
   logic [WIDTH-1:0] mq_q;       // Booth multiplier / divide quotient
   logic [WIDTH-1:0] m_q;        // multiplicand / divisor magnitude
   logic             q1_q;       // Booth q(-1) bit
   logic             neg_quo_q;  // negate quotient in FIX
   logic             neg_rem_q;  // negate remainder in FIX
   logic             div0_q;     // current completion is a divide by zero
   logic [WIDTH-1:0] hi_q, lo_q;

   // ---------------------------------------------------------------------
   // Start decode
   // ---------------------------------------------------------------------
   logic w_start_div0;
   logic w_start_early;

   assign w_start_div0 = start && (op == OP_DIV) && (b == '0);

`ifdef MULT_DIV_EARLY_OUT_EN
   assign w_start_early = start && (op == OP_MULT) && ((a == '0) || (b == '0));
`else
   assign w_start_early = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Operand magnitudes and result sign correction
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic [WIDTH-1:0] w_hi_fix, w_lo_fix;

   md_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
      .val_i (a),
      .neg_i (a[WIDTH-1]),
      .res_o (w_a_mag)
   );

   md_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
      .val_i (b),
      .neg_i (b[WIDTH-1]),
      .res_o (w_b_mag)
   );

   // For MULT both negate flags are clear, so FIX passes {acc, mq} through.
   md_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
      .val_i (acc_q),
      .neg_i (neg_rem_q),
      .res_o (w_hi_fix)
   );

   md_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
      .val_i (mq_q),
      .neg_i (neg_quo_q),
      .res_o (w_lo_fix)
   );

   // ---------------------------------------------------------------------
   // Booth step. The add/subtract is done one bit wider than the
   // accumulator so that a most-negative multiplicand cannot overflow
   // before the arithmetic shift; the shifted value always fits back
   // into WIDTH bits.
   // ---------------------------------------------------------------------
   logic [WIDTH:0] w_acc_ext, w_m_ext, w_booth_sum;

   assign w_acc_ext = {acc_q[WIDTH-1], acc_q};
   assign w_m_ext   = {m_q[WIDTH-1], m_q};

   always_comb begin
      w_booth_sum = w_acc_ext;
      case ({mq_q[0], q1_q})
         2'b01:   w_booth_sum = w_acc_ext + w_m_ext;
         2'b10:   w_booth_sum = w_acc_ext - w_m_ext;
         default: w_booth_sum = w_acc_ext;
      endcase
   end

   // ---------------------------------------------------------------------
   // Restoring divide step. The partial remainder is always below the
   // divisor, so the shifted trial value needs one extra bit and the
   // difference (when taken) fits back into WIDTH bits.
   // ---------------------------------------------------------------------
   logic [WIDTH:0]   w_trial;
   logic             w_trial_ge;
   logic [WIDTH-1:0] w_trial_diff;
   logic [WIDTH-1:0] w_rem_next;

   assign w_trial      = {acc_q, mq_q[WIDTH-1]};
   assign w_trial_ge   = (w_trial >= {1'b0, m_q});
   assign w_trial_diff = w_trial[WIDTH-1:0] - m_q;
   assign w_rem_next   = w_trial_ge ? w_trial_diff : w_trial[WIDTH-1:0];

   logic             w_last_iter;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_last_iter = (cnt_q == CNT_LAST);
   assign w_cnt_next  = w_last_iter ? '0 : (cnt_q + CNT_W'(1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (w_start_div0 || w_start_early) begin
                  state_d = DONE;
               end else if (op == OP_DIV) begin
                  state_d = DIV;
               end else begin
                  state_d = MULT;
               end
            end
         end
         MULT, DIV: begin
            if (w_last_iter) begin
               state_d = FIX;
            end
         end
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs, decoded from registered state only
   // ---------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      div0 = 1'b0;
      if (state_q != IDLE) begin
         busy = 1'b1;
      end
      if (state_q == DONE) begin
         done = 1'b1;
         div0 = div0_q;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         m_q       <= '0;
         q1_q      <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  q1_q   <= 1'b0;
                  div0_q <= w_start_div0;
                  if (op == OP_DIV) begin
                     mq_q      <= w_a_mag;
                     m_q       <= w_b_mag;
                     neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_rem_q <= a[WIDTH-1];
                  end else begin
                     mq_q      <= b;
                     m_q       <= a;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                  end
                  if (w_start_early) begin
                     hi_q <= '0;
                     lo_q <= '0;
                  end
               end
            end
            MULT: begin
               acc_q <= w_booth_sum[WIDTH:1];
               mq_q  <= {w_booth_sum[0], mq_q[WIDTH-1:1]};
               q1_q  <= mq_q[0];
               cnt_q <= w_cnt_next;
            end
            DIV: begin
               acc_q <= w_rem_next;
               mq_q  <= {mq_q[WIDTH-2:0], w_trial_ge};
               cnt_q <= w_cnt_next;
            end
            FIX: begin
               hi_q <= w_hi_fix;
               lo_q <= w_lo_fix;
            end
            default: begin
            end
         endcase
      end
   end

endmodule : mult_div_seq
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_seq
//  Description : Self-checking bench for mult_div_seq (WIDTH = 32). Expected
//                results come from a 64-bit signed reference model and are
//                queued when a request is driven, then popped at done.
//  Config      : MULT_DIV_EARLY_OUT_EN - expected early-out latency follows
//                the same macro as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           lat;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div0;

   int   n_tests;
   int   n_fail;
   int   cyc;
   exp_t sb[$];
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   mult_div_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done),
      .div0  (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: exact signed product, truncating signed divide.
   function automatic exp_t model(input logic o, input logic [W-1:0] ta, input logic [W-1:0] tbv);
      exp_t   e;
      longint sa, sbv, p, q, r;
      sa     = longint'($signed(ta));
      sbv    = longint'($signed(tbv));
      e.hi   = m_hi;
      e.lo   = m_lo;
      e.div0 = 1'b0;
      e.lat  = W + 2;
      if (o == 1'b0) begin
         p    = sa * sbv;
         e.hi = p[63:32];
         e.lo = p[31:0];
`ifdef MULT_DIV_EARLY_OUT_EN
         if (ta == '0 || tbv == '0) e.lat = 1;
`endif
      end else if (tbv == '0) begin
         e.div0 = 1'b1;
         e.lat  = 1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      if (!e.div0) begin
         m_hi = e.hi;
         m_lo = e.lo;
      end
      return e;
   endfunction

   // Drive one request across edge 0; afterwards scramble the operand pins.
   task automatic launch(input logic o, input logic [W-1:0] ta, input logic [W-1:0] tbv);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = ta;
      b     = tbv;
      sb.push_back(model(o, ta, tbv));
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
      cyc   = 1;
   endtask

   // Wait (bounded) for done, then compare against the scoreboard head.
   task automatic finish_op(input string tag);
      exp_t e;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
      chk({tag, "_sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
      if (done && sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
         chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
         chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
         chk({tag, "_div0"}, {63'd0, div0}, {63'd0, e.div0});
      end
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int n_done;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      m_hi    = '0;
      m_lo    = '0;
      reset   = 1'b1;
      start   = 1'b0;
      op      = 1'b0;
      a       = '0;
      b       = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_div0", {63'd0, div0}, 64'd0);

      // MULT 7 x -3, busy during the run
      launch(1'b0, 32'd7, 32'hFFFF_FFFD);
      chk("m7_busy", {63'd0, busy}, 64'd1);
      finish_op("m7");
      chk("m7_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("m7_lo_const", {32'd0, lo}, 64'hFFFF_FFEB);

      launch(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      finish_op("mmax");
      chk("mmax_hi_const", {32'd0, hi}, 64'h3FFF_FFFF);
      chk("mmax_lo_const", {32'd0, lo}, 64'h0000_0001);

      launch(1'b0, 32'h8000_0000, 32'h8000_0000);
      finish_op("mmin");
      chk("mmin_hi_const", {32'd0, hi}, 64'h4000_0000);
      chk("mmin_lo_const", {32'd0, lo}, 64'h0);

      launch(1'b1, 32'hFFFF_FFF9, 32'd2);
      finish_op("dneg");
      chk("dneg_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
      chk("dneg_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);

      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("dovf");
      chk("dovf_lo_const", {32'd0, lo}, 64'h8000_0000);
      chk("dovf_hi_const", {32'd0, hi}, 64'h0);

      // Divide by zero keeps the previous 5/6 result
      launch(1'b1, 32'd47, 32'd7);
      finish_op("d47");
      launch(1'b1, 32'd99, 32'd0);
      finish_op("dz");
      chk("dz_hi_kept", {32'd0, hi}, 64'd5);
      chk("dz_lo_kept", {32'd0, lo}, 64'd6);
      launch(1'b1, 32'd10, 32'd3);
      finish_op("d10");
      chk("d10_lo_const", {32'd0, lo}, 64'd3);
      chk("d10_hi_const", {32'd0, hi}, 64'd1);

      // Start pulse at cycle 10 of a running MULT is ignored
      launch(1'b0, 32'd1234, 32'hFFFF_F000);
      repeat (9) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("ign_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'd55;
      b     = 32'd0;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      finish_op("ign");

      // Reset at cycle 20 of a MULT aborts it
      launch(1'b0, 32'h0012_3456, 32'h0000_0789);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(sb.pop_back());
      m_hi = '0;
      m_lo = '0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hi", {32'd0, hi}, 64'd0);
      chk("abort_lo", {32'd0, lo}, 64'd0);
      n_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      chk("abort_no_done", 64'(n_done), 64'd0);

      // Zero-operand MULT (early-out when enabled)
      launch(1'b0, 32'd0, 32'h0000_1234);
      finish_op("mzero");

      // Mixed random operations
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         if (i == 5) rb = {28'd0, 4'($urandom)} + 32'd1;
         launch(1'(i % 2), ra, rb);
         finish_op($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mult_div_seq
`default_nettype wire
